// File: rtl/dac_ctrl.sv
// dac_ctrl: buffers per-channel DAC writes and sequences them one at a time into dacspi.
// Build option DAC_CTRL_FIFO_EN: 4-entry FIFO; when undefined, a single holding register.
module dac_ctrl #(
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        spi_sck_trig,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_channel,
    input  logic [11:0] wr_value,
    input  logic        wr_update,
    output logic [11:0] dac_data,
    output logic [3:0]  dac_address,
    output logic [3:0]  dac_command,
    output logic        dactrig,
    input  logic        dacdone,
    output logic        busy,
    output logic [2:0]  level,
    output logic        err_timeout,
    input  logic        clr_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a write transfers on every rising edge where wr_valid & wr_ready are both high;
    // wr_ready depends only on RST and occupancy, never on wr_valid.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_TRIG = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int         ENTRY_W  = 15;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_TICKS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    state_t               state_q, state_d;
    logic [7:0]           tick_q;
    logic                 tick_clr, tick_inc, set_err;
    logic                 push, pop;
    logic [ENTRY_W-1:0]   head;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [2:0]           count_q;

    assign wr_entry = {wr_update, wr_channel, wr_value};
    assign push     = wr_valid & wr_ready;
    assign pop      = (state_q == S_LOAD);

`ifdef DAC_CTRL_FIFO_EN
    logic [ENTRY_W-1:0] mem [4];
    logic [1:0]         wr_ptr, rd_ptr;

    assign wr_ready = RST & (count_q != 3'd4);
    assign head     = mem[rd_ptr];

    always_ff @(posedge CLK50MHZ) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [ENTRY_W-1:0] hold_q;

    // The register frees up in LOAD, so a new write can land while the transfer is in TRIG.
    assign wr_ready = RST & (count_q == 3'd0);
    assign head     = hold_q;

    always_ff @(posedge CLK50MHZ) begin
        if (push) begin
            hold_q <= wr_entry;
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            count_q <= 3'd0;
        end else if (push) begin
            count_q <= 3'd1;
        end else if (pop) begin
            count_q <= 3'd0;
        end
    end
`endif

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_clr = 1'b0;
        tick_inc = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d  = S_TRIG;
                tick_clr = 1'b1;
            end
            S_TRIG: begin
                // A completion in the same cycle as the last allowed tick counts as success.
                if (dacdone) begin
                    state_d  = S_GAP;
                    tick_clr = 1'b1;
                end else if (spi_sck_trig) begin
                    if (tick_q == TO_LAST) begin
                        set_err  = 1'b1;
                        state_d  = S_GAP;
                        tick_clr = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (spi_sck_trig) begin
                    if (tick_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            tick_q      <= 8'd0;
            dac_data    <= 12'd0;
            dac_address <= 4'd0;
            dac_command <= 4'd0;
            dactrig     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (tick_clr) begin
                tick_q <= 8'd0;
            end else if (tick_inc) begin
                tick_q <= tick_q + 8'd1;
            end
            if (pop) begin
                dac_data    <= head[11:0];
                dac_address <= {2'b00, head[13:12]};
                dac_command <= head[14] ? 4'b0011 : 4'b0000;
            end
            dactrig <= (state_d == S_TRIG);
            if (set_err) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

    assign level     = count_q;
    assign busy      = (state_q != S_IDLE) | (count_q != 3'd0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dac_ctrl.sv
// tb_dac_ctrl: randomized bench for dac_ctrl with a transfer-lifecycle reference model,
// an expected-write scoreboard and directed literal checks.
`timescale 1ns/1ps
module tb_dac_ctrl;

    localparam int GAP = 2;
    localparam int TMO = 8;
`ifdef DAC_CTRL_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int T5_LVL = (DEPTH < 3) ? DEPTH : 3;

    localparam int WAITING  = 0;
    localparam int FETCHING = 1;
    localparam int DRIVING  = 2;
    localparam int SETTLING = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck_tick = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_channel = 2'd0;
    logic [11:0] wr_value = 12'd0;
    logic        wr_update = 1'b0;
    logic        dacdone = 1'b0;
    logic        clr_err = 1'b0;
    logic        wr_ready, dactrig, busy, err_timeout;
    logic [11:0] dac_data;
    logic [3:0]  dac_address, dac_command;
    logic [2:0]  level;
    logic [1:0]  dbg_state;

    always #10 clk = ~clk;

    dac_ctrl #(.GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (
        .CLK50MHZ(clk), .RST(rst_n), .spi_sck_trig(sck_tick),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
        .wr_value(wr_value), .wr_update(wr_update), .dac_data(dac_data),
        .dac_address(dac_address), .dac_command(dac_command), .dactrig(dactrig),
        .dacdone(dacdone), .busy(busy), .level(level), .err_timeout(err_timeout),
        .clr_err(clr_err), .dbg_state(dbg_state)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    bit          cmp_en = 1'b0;
    bit          stall_done = 1'b0;
    bit          sck_off = 1'b0;
    int          done_wait = 3;
    logic        prev_trig = 1'b0;
    logic [14:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within budget (required event) at %0t", name, $time);
    endtask

    // ---------------- SPI tick source and dacspi completion responder ----------------
    always @(negedge clk) begin
        #1;
        sck_tick = !sck_off && ($urandom_range(0, 2) == 0);
        if (dactrig && !dacdone && !stall_done) begin
            if (done_wait == 0) begin
                dacdone   = 1'b1;
                done_wait = $urandom_range(0, 10);
            end else begin
                dacdone = 1'b0;
                done_wait--;
            end
        end else begin
            dacdone = 1'b0;
        end
    end

    // ---------------- reference model: buffer queue plus transfer lifecycle ----------------
    logic [14:0] mq[$];
    int          m_phase = WAITING;
    int          m_cnt = 0;
    logic        m_trig = 1'b0;
    logic        m_err = 1'b0;
    logic [11:0] m_data = 12'd0;
    logic [3:0]  m_addr = 4'd0;
    logic [3:0]  m_cmd = 4'd0;
    logic [14:0] m_e;
    bit          m_push, m_timeout;

    always @(posedge clk) begin
        m_push    = rst_n && wr_valid && (mq.size() < DEPTH);
        m_timeout = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_phase = WAITING;
            m_cnt   = 0;
            m_trig  = 1'b0;
            m_err   = 1'b0;
            m_data  = 12'd0;
            m_addr  = 4'd0;
            m_cmd   = 4'd0;
        end else begin
            case (m_phase)
                WAITING:  if (mq.size() != 0) m_phase = FETCHING;
                FETCHING: begin
                    m_e     = mq.pop_front();
                    m_data  = m_e[11:0];
                    m_addr  = {2'b00, m_e[13:12]};
                    m_cmd   = m_e[14] ? 4'h3 : 4'h0;
                    m_phase = DRIVING;
                    m_cnt   = 0;
                end
                DRIVING: begin
                    if (dacdone) begin
                        m_phase = SETTLING;
                        m_cnt   = 0;
                    end else if (sck_tick) begin
                        m_cnt++;
                        if (m_cnt == TMO) begin
                            m_timeout = 1'b1;
                            m_phase   = SETTLING;
                            m_cnt     = 0;
                        end
                    end
                end
                default: begin
                    if (sck_tick) begin
                        m_cnt++;
                        if (m_cnt == GAP) m_phase = WAITING;
                    end
                end
            endcase
            if (m_timeout) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            m_trig = (m_phase == DRIVING);
            if (m_push) mq.push_back({wr_update, wr_channel, wr_value});
        end
    end

    // ---------------- compare process and scoreboard ----------------
    logic [14:0] sb_e;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("dactrig", 32'(dactrig), 32'(m_trig));
            check("dac_data", 32'(dac_data), 32'(m_data));
            check("dac_address", 32'(dac_address), 32'(m_addr));
            check("dac_command", 32'(dac_command), 32'(m_cmd));
            check("level", 32'(level), 32'(mq.size()));
            check("busy", 32'(busy), 32'((m_phase != WAITING) || (mq.size() != 0)));
            check("wr_ready", 32'(wr_ready), 32'(rst_n && (mq.size() < DEPTH)));
            check("err_timeout", 32'(err_timeout), 32'(m_err));
            if (dactrig && !prev_trig) begin
                if (exp_q.size() == 0) begin
                    fail_now("sb_unexpected_transfer");
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_data", 32'(dac_data), 32'(sb_e[11:0]));
                    check("sb_addr", 32'(dac_address), 32'({2'b00, sb_e[13:12]}));
                    check("sb_cmd", 32'(dac_command), sb_e[14] ? 32'h3 : 32'h0);
                end
            end
            prev_trig = dactrig;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_cycle(input logic [1:0] ch, input logic [11:0] val, input logic upd,
                               output bit ok);
        @(negedge clk);
        #1;
        wr_valid   = 1'b1;
        wr_channel = ch;
        wr_value   = val;
        wr_update  = upd;
        ok = rst_n && (mq.size() < DEPTH);
        @(posedge clk);
        if (ok) exp_q.push_back({upd, ch, val});
    endtask

    task automatic write_until(input logic [1:0] ch, input logic [11:0] val, input logic upd,
                               input string name);
        bit ok = 1'b0;
        int n = 0;
        while (!ok && n < 200) begin
            write_cycle(ch, val, upd, ok);
            n++;
        end
        if (!ok) fail_now(name);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_trig(input logic want, input int budget, input string name);
        int n = 0;
        while (dactrig !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dactrig !== want) fail_now(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy !== 1'b0 || dactrig !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) fail_now(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int acc;
        int n;
        bit ok;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_trig", 32'(dactrig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_data", 32'(dac_data), 32'd0);
        #1 rst_n = 1'b1;

        // single write: latency and register contents
        stall_done = 1'b1;
        write_cycle(2'd2, 12'hABC, 1'b1, ok);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (dactrig === 1'b1) lat = k;
            #1 wr_valid = 1'b0;
        end
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_data", 32'(dac_data), 32'hABC);
        check("t1_addr", 32'(dac_address), 32'h2);
        check("t1_cmd", 32'(dac_command), 32'h3);
        stall_done = 1'b0;
        wait_idle(300, "t1_idle");

        // fill while the active transfer is stalled, then drain in order
        stall_done = 1'b1;
        sck_off    = 1'b1;
        write_until(2'd0, 12'h111, 1'b1, "t2_first");
        idle();
        wait_trig(1'b1, 20, "t2_trig");
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            write_cycle(2'(i), 12'h200 + 12'(i), 1'(i % 2), ok);
            if (ok) acc++;
        end
        idle();
        check("t2_accepted", 32'(acc), 32'(DEPTH));
        check("t2_level", 32'(level), 32'(DEPTH));
        check("t2_ready_full", 32'(wr_ready), 32'd0);
        sck_off    = 1'b0;
        stall_done = 1'b0;
        wait_idle(2000, "t2_drain");

        // write-only command
        write_until(2'd1, 12'h5A5, 1'b0, "t3_write");
        idle();
        wait_trig(1'b1, 20, "t3_trig");
        check("t3_cmd", 32'(dac_command), 32'h0);
        check("t3_addr", 32'(dac_address), 32'h1);
        check("t3_data", 32'(dac_data), 32'h5A5);
        wait_idle(300, "t3_idle");

        // timeout, drop, next entry proceeds
        stall_done = 1'b1;
        write_until(2'd3, 12'h0F0, 1'b1, "t4_first");
        idle();
        wait_trig(1'b1, 20, "t4_trig");
        write_until(2'd1, 12'h321, 1'b0, "t4_second");
        idle();
        n = 0;
        while (err_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4_err_set", 32'(err_timeout), 32'd1);
        check("t4_trig_low", 32'(dactrig), 32'd0);
        stall_done = 1'b0;
        wait_idle(500, "t4_next");
        @(negedge clk);
        #1 clr_err = 1'b1;
        @(negedge clk);
        check("t4_clr", 32'(err_timeout), 32'd0);
        // clr_err held through a fresh timeout: the set must win
        stall_done = 1'b1;
        write_until(2'd0, 12'h777, 1'b1, "t4_third");
        idle();
        n = 0;
        while (err_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4_set_wins", 32'(err_timeout), 32'd1);
        #1 clr_err = 1'b0;
        @(negedge clk);
        check("t4_sticky", 32'(err_timeout), 32'd1);
        stall_done = 1'b0;
        wait_idle(500, "t4_idle");

        // reset in the middle of a transfer with entries buffered
        stall_done = 1'b1;
        sck_off    = 1'b1;
        write_until(2'd2, 12'h9C3, 1'b1, "t5_first");
        idle();
        wait_trig(1'b1, 20, "t5_trig");
        for (int i = 0; i < 3; i++) begin
            write_cycle(2'(i), 12'h400 + 12'(i), 1'b1, ok);
        end
        idle();
        check("t5_level_pre", 32'(level), 32'(T5_LVL));
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_trig", 32'(dactrig), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_data", 32'(dac_data), 32'd0);
        check("t5_addr", 32'(dac_address), 32'd0);
        check("t5_cmd", 32'(dac_command), 32'd0);
        check("t5_ready", 32'(wr_ready), 32'd0);
        #1 rst_n = 1'b1;
        sck_off    = 1'b0;
        stall_done = 1'b0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #1;
            wr_valid   = ($urandom_range(0, 2) == 0);
            wr_channel = 2'($urandom_range(0, 3));
            wr_value   = 12'($urandom_range(0, 4095));
            wr_update  = 1'($urandom_range(0, 1));
            clr_err    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) stall_done = !stall_done;
            ok = wr_valid && rst_n && (mq.size() < DEPTH);
            @(posedge clk);
            if (ok) exp_q.push_back({wr_update, wr_channel, wr_value});
        end
        idle();
        clr_err    = 1'b0;
        stall_done = 1'b0;
        wait_idle(3000, "final_drain");
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
